// File: rtl/pc_gen.sv
// pc_gen: program counter generator with fixed-priority redirect selection
// (trap > mret > branch/jump) and a RUN/HOLD FSM that remembers a redirect
// arriving while the pipeline is stalled.
// Optional feature: define PC_VECTORED_TRAP_EN to enable vectored trap entry
// for interrupts (mtvec mode 2'b01, mcause MSB set).
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal fetch; PC advances or redirects when not stalled
// HOLD  | stalled with a redirect latched; applied when stall drops
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_true,
    input  logic            jump_en,
    input  logic [XLEN-1:0] alu_result,
    input  logic            epc_taken,
    input  logic [XLEN-1:0] epc,
    input  logic            trap_en,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect_pending,
    output logic            misalign
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_lat_tgt;
    logic            r_lat_trap;

    logic            w_redir;
    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_trap_tgt;
    logic [XLEN-1:0] w_raw_tgt;
    logic [XLEN-1:0] w_tgt;
    logic [XLEN-1:0] w_next_pc;
    logic            w_unused;

    assign w_redir     = trap_en | epc_taken | br_true | jump_en;
    assign w_trap_base = {mtvec[XLEN-1:2], 2'b00};

    // Only some mtvec/mcause bits shape the target in either build.
    assign w_unused = ^{mtvec[1:0], mcause};

`ifdef PC_VECTORED_TRAP_EN
    // Vectored mode adds 4*cause for interrupts; the shift drops the top
    // cause bits, which is the modulo-2^XLEN truncation we want.
    always_comb begin
        w_trap_tgt = w_trap_base;
        if (mtvec[1:0] == 2'b01 && mcause[XLEN-1])
            w_trap_tgt = w_trap_base + {mcause[XLEN-3:0], 2'b00};
    end
`else
    // Direct mode only: every trap enters at the aligned base.
    always_comb begin
        w_trap_tgt = w_trap_base;
    end
`endif

    // Fixed-priority redirect source; bit 0 is always cleared, bit 1 is kept
    // so a misaligned target can be flagged.
    always_comb begin
        w_raw_tgt = alu_result;
        if (trap_en)
            w_raw_tgt = w_trap_tgt;
        else if (epc_taken)
            w_raw_tgt = epc;
        w_tgt = {w_raw_tgt[XLEN-1:1], 1'b0};
    end

    // Next PC: the exact value the register takes at the coming edge.
    always_comb begin
        w_next_pc = r_pc;
        if (rst) begin
            w_next_pc = RESET_VECTOR;
        end else if (!stall) begin
            if (r_state == HOLD)
                w_next_pc = trap_en ? w_tgt : r_lat_tgt;
            else
                w_next_pc = w_redir ? w_tgt : r_pc + XLEN'(4);
        end
    end

    // PC register and RUN/HOLD FSM with the latched redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_VECTOR;
            r_state    <= RUN;
            r_lat_tgt  <= {XLEN{1'b0}};
            r_lat_trap <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            case (r_state)
                RUN: begin
                    if (stall && w_redir) begin
                        r_lat_tgt  <= w_tgt;
                        r_lat_trap <= trap_en;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (stall) begin
                        // A latched trap is never displaced by a lesser redirect.
                        if (w_redir && !(r_lat_trap && !trap_en)) begin
                            r_lat_tgt  <= w_tgt;
                            r_lat_trap <= trap_en;
                        end
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign pc_out           = r_pc;
    assign next_pc          = w_next_pc;
    assign redirect_pending = (r_state == HOLD);
    assign misalign         = !rst && w_redir && w_tgt[1];

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: expected PC values are queued as each cycle's stimulus
// is driven and compared against pc_out just after the following edge.
module tb_pc_gen;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0100;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            br_true;
    logic            jump_en;
    logic [XLEN-1:0] alu_result;
    logic            epc_taken;
    logic [XLEN-1:0] epc;
    logic            trap_en;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] next_pc;
    logic            redirect_pending;
    logic            misalign;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb[$];
    logic [31:0] mon_exp;

    pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .br_true          (br_true),
        .jump_en          (jump_en),
        .alu_result       (alu_result),
        .epc_taken        (epc_taken),
        .epc              (epc),
        .trap_en          (trap_en),
        .mtvec            (mtvec),
        .mcause           (mcause),
        .pc_out           (pc_out),
        .next_pc          (next_pc),
        .redirect_pending (redirect_pending),
        .misalign         (misalign)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: one expected PC per clock edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            checks++;
            if (pc_out !== mon_exp) begin
                failures++;
                $display("FAIL pc_out t=%0t got=%h exp=%h", $time, pc_out, mon_exp);
            end
        end
    end

    task automatic clear_in();
        br_true = 0; jump_en = 0; alu_result = '0;
        epc_taken = 0; epc = '0; trap_en = 0; mtvec = '0; mcause = '0;
    endtask

    task automatic tick(input logic [31:0] exp_pc);
        sb.push_back(exp_pc);
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; clear_in();
        br_true = 1; alu_result = 32'h33; trap_en = 1; mtvec = 32'h200;
        #1;
        checks++;
        if (next_pc !== RV) begin failures++; $display("FAIL rst_next_pc got=%h exp=%h", next_pc, RV); end
        checks++;
        if (misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", misalign); end
        tick(RV);
        tick(RV);
        checks++;
        if (redirect_pending !== 1'b0) begin failures++; $display("FAIL rst_pending got=%b exp=0", redirect_pending); end
        rst = 0; clear_in();
        tick(32'h104);
        tick(32'h108);
        tick(32'h10C);
    endtask

    task automatic test_priority();
        trap_en = 1; mtvec = 32'h200; epc_taken = 1; epc = 32'h300;
        br_true = 1; alu_result = 32'h400;
        #1;
        checks++;
        if (next_pc !== 32'h200) begin failures++; $display("FAIL prio_next_pc got=%h exp=200", next_pc); end
        checks++;
        if (misalign !== 1'b0) begin failures++; $display("FAIL prio_misalign got=%b exp=0", misalign); end
        tick(32'h200);
        clear_in(); epc_taken = 1; epc = 32'h500; br_true = 1; alu_result = 32'h600;
        tick(32'h500);
        clear_in(); jump_en = 1; alu_result = 32'h701;
        #1;
        checks++;
        if (misalign !== 1'b0) begin failures++; $display("FAIL bit0_misalign got=%b exp=0", misalign); end
        tick(32'h700);
        clear_in();
    endtask

    task automatic test_misalign_wrap();
        br_true = 1; alu_result = 32'h33;
        #1;
        checks++;
        if (misalign !== 1'b1) begin failures++; $display("FAIL misalign_set got=%b exp=1", misalign); end
        tick(32'h32);
        clear_in();
        #1;
        checks++;
        if (misalign !== 1'b0) begin failures++; $display("FAIL misalign_seq got=%b exp=0", misalign); end
        tick(32'h36);
        jump_en = 1; alu_result = 32'hFFFF_FFFC;
        tick(32'hFFFF_FFFC);
        clear_in();
        #1;
        checks++;
        if (next_pc !== 32'h0) begin failures++; $display("FAIL wrap_next_pc got=%h exp=0", next_pc); end
        tick(32'h0);
    endtask

    task automatic test_stall_hold();
        stall = 1;
        tick(32'h0);
        checks++;
        if (redirect_pending !== 1'b0) begin failures++; $display("FAIL stall_no_redir_pending got=%b exp=0", redirect_pending); end
        jump_en = 1; alu_result = 32'h40;
        tick(32'h0);
        clear_in();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (redirect_pending !== 1'b1) begin failures++; $display("FAIL hold_pending i=%0d got=%b exp=1", i, redirect_pending); end
            tick(32'h0);
        end
        stall = 0;
        #1;
        checks++;
        if (next_pc !== 32'h40) begin failures++; $display("FAIL release_next_pc got=%h exp=40", next_pc); end
        tick(32'h40);
        checks++;
        if (redirect_pending !== 1'b0) begin failures++; $display("FAIL release_pending got=%b exp=0", redirect_pending); end

        stall = 1; trap_en = 1; mtvec = 32'h200;
        tick(32'h40);
        clear_in(); br_true = 1; alu_result = 32'h80;
        tick(32'h40);
        clear_in(); stall = 0;
        tick(32'h200);

        stall = 1; br_true = 1; alu_result = 32'h80;
        tick(32'h200);
        clear_in(); jump_en = 1; alu_result = 32'h90;
        tick(32'h200);
        clear_in(); stall = 0;
        tick(32'h90);

        stall = 1; br_true = 1; alu_result = 32'hA0;
        tick(32'h90);
        clear_in(); stall = 0; trap_en = 1; mtvec = 32'h240;
        #1;
        checks++;
        if (next_pc !== 32'h240) begin failures++; $display("FAIL release_trap_next_pc got=%h exp=240", next_pc); end
        tick(32'h240);

        clear_in(); stall = 1; jump_en = 1; alu_result = 32'hA0;
        tick(32'h240);
        clear_in(); stall = 0; br_true = 1; alu_result = 32'hB0;
        #1;
        checks++;
        if (next_pc !== 32'hA0) begin failures++; $display("FAIL release_drop_next_pc got=%h exp=a0", next_pc); end
        tick(32'hA0);
        clear_in();
        tick(32'hA4);
    endtask

    task automatic test_reset_in_hold();
        stall = 1; jump_en = 1; alu_result = 32'h300;
        tick(32'hA4);
        checks++;
        if (redirect_pending !== 1'b1) begin failures++; $display("FAIL rih_pending got=%b exp=1", redirect_pending); end
        clear_in(); rst = 1;
        tick(RV);
        checks++;
        if (redirect_pending !== 1'b0) begin failures++; $display("FAIL rih_cleared got=%b exp=0", redirect_pending); end
        rst = 0; stall = 0;
        tick(32'h104);
        tick(32'h108);
    endtask

    task automatic test_vectored();
        trap_en = 1; mtvec = 32'h1001; mcause = 32'h8000_0007;
`ifdef PC_VECTORED_TRAP_EN
        tick(32'h101C);
`else
        tick(32'h1000);
`endif
        mcause = 32'h0000_0007;
        tick(32'h1000);
        clear_in();
        tick(32'h1004);
    endtask

    initial begin
        rst = 1; stall = 0; clear_in();
        #2;
        test_reset();
        test_priority();
        test_misalign_wrap();
        test_stall_hold();
        test_reset_in_hold();
        test_vectored();
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and PC width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning PC value after reset.
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port stall, input, 1, holds the PC when high.
REQ-006 SHALL have port br_true, input, 1, branch taken.
REQ-007 SHALL have port jump_en, input, 1, jump (JAL/JALR).
REQ-008 SHALL have port alu_result, input, XLEN, branch/jump target.
REQ-009 SHALL have port epc_taken, input, 1, return from trap (MRET).
REQ-010 SHALL have port epc, input, XLEN, return target.
REQ-011 SHALL have port trap_en, input, 1, trap entry request.
REQ-012 SHALL have port mtvec, input, XLEN, trap vector CSR.
REQ-013 SHALL have port mcause, input, XLEN, trap cause CSR; the MSB is the interrupt flag.
REQ-014 SHALL have port pc_out, output, XLEN, current PC register.
REQ-015 SHALL have port next_pc, output, XLEN, value pc_out loads at the next edge (combinational).
REQ-016 SHALL have port redirect_pending, output, 1, a redirect is latched while stalled.
REQ-017 SHALL have port misalign, output, 1, the selected redirect target has bit 1 set (combinational).

Function
REQ-018 SHALL select the redirect source by fixed priority: trap_en, then epc_taken, then (br_true or jump_en); the sequential path is pc_out + 4.
REQ-019 SHALL form the trap target as {mtvec[XLEN-1:2], 2'b00}, except as modified by REQ-036.
REQ-020 SHALL clear bit 0 of every redirect target and SHALL load bit 1 unmodified.
REQ-021 SHALL assert misalign when a redirect is selected and its target bit 1 = 1; misalign SHALL be 0 otherwise.
REQ-022 SHALL implement a two-state FSM, RUN and HOLD, where redirect_pending = (state == HOLD).
REQ-023 In RUN with stall=0, SHALL load the PC with the selected redirect target, or pc_out + 4 if there is none.
REQ-024 In RUN with stall=1 and no redirect, SHALL hold the PC and stay in RUN.
REQ-025 In RUN with stall=1 and a redirect, SHALL hold the PC, latch the target and whether it is a trap, and go to HOLD.
REQ-026 In HOLD with stall=1 and a new redirect, SHALL overwrite the latched target, unless the latched target is a trap and the new redirect is not.
REQ-027 In HOLD with stall=0, SHALL load the PC with the latched target and return to RUN; a same-cycle trap_en SHALL win, and same-cycle non-trap redirects SHALL be dropped.
REQ-028 SHALL drive next_pc equal to the PC value that the rules above produce at the next edge, including held values.
REQ-029 SHALL perform all PC arithmetic modulo 2^XLEN; the incrementer wraps from all-ones-minus-3 to 0.
REQ-030 SHALL have a latency of one cycle from a redirect input (unstalled) to the target appearing on pc_out.

Reset
REQ-031 While rst=1, SHALL set pc_out to RESET_VECTOR at each edge, the state to RUN, the latched target to 0 and the latched trap flag to 0.
REQ-032 While rst=1, SHALL drive next_pc = RESET_VECTOR and misalign = 0, and SHALL ignore all other inputs.
REQ-033 Reset asserted in HOLD SHALL discard the pending redirect; after release, execution SHALL resume from RESET_VECTOR.

Configuration
REQ-034 SHALL use the macro PC_VECTORED_TRAP_EN to compile vectored trap entry in or out.
REQ-035 Without the macro, SHALL ignore mtvec[1:0] and mcause for target formation.
REQ-036 With the macro, when mtvec[1:0]=2'b01 and mcause[XLEN-1]=1, SHALL set the trap target to {mtvec[XLEN-1:2],2'b00} + (mcause[XLEN-2:0] << 2), truncated to XLEN; otherwise the target is per REQ-019.

Verification
REQ-037 Scenario: reset with RESET_VECTOR=0x100, release, no stall for 3 cycles -> pc_out = 0x100, 0x104, 0x108, 0x10C.
REQ-038 Scenario: same cycle trap_en=1, mtvec=0x200, epc_taken=1, br_true=1 -> next cycle pc_out = 0x200 and misalign = 0.
REQ-039 Scenario: stall=1, jump_en=1 with alu_result=0x40, then a stall of 3 cycles -> pc_out held and redirect_pending=1; on stall release pc_out = 0x40 and redirect_pending = 0.
REQ-040 Scenario: in HOLD with a trap latched (0x200), br_true=1 with target 0x80 while stalled -> release loads 0x200.
REQ-041 Scenario: br_true=1, alu_result=0x33 -> misalign=1, next cycle pc_out = 0x32; pc_out=0xFFFF_FFFC sequential -> pc_out = 0x0.
REQ-042 Scenario (macro defined): mtvec=0x1001, mcause=0x8000_0007, trap_en=1 -> pc_out = 0x101C; same stimulus without the macro -> pc_out = 0x1000.
